// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive path: default geometry of the
// receive FIFO and the stored frame layout.
//
// Contents:
//   DEF_DEPTH     default number of frame entries in the receive FIFO
//   DEF_DATA_W    default data bits per frame
//   FLAG_W        number of per-frame error flags stored with the data
//   rx_frame_t    frame record at the default data width {data, perr, serr}
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DATA_W = 8;
    localparam int FLAG_W     = 2;

    // Field order matches the packed word written into FIFO storage:
    // data in the upper bits, parity flag, then stop flag in bit 0.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  perr;
        logic                  serr;
    } rx_frame_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_mem
// Frame storage for the UART receive FIFO: a plain register array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; the owner tracks which entries are valid.
//
// Ports:
//   clk      in   clock, writes on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   word to store
//   rd_addr  in   read index
//   rd_data  out  word at rd_addr (combinational)
// -----------------------------------------------------------------------------
module uart_rx_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side frame FIFO sitting behind a UART RX top. Each completed frame
// (data plus parity/stop error flags) is queued and presented to a consumer
// through a valid/ready head interface.
//
// Optional feature (macro UART_RX_FIFO_DROP_ERR_EN):
//   defined   - frames flagged with parity or stop error are discarded and
//               counted on err_drop_cnt (saturating 8-bit counter)
//   undefined - every frame is stored with its flags; no err_drop_cnt port
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   P_DATA        in   received data from RX top
//   data_valid    in   one-cycle pulse: frame on P_DATA/flags is complete
//   parity_error  in   parity flag, qualified by data_valid
//   stop_error    in   stop flag, qualified by data_valid
//   out_data      out  head-entry data
//   out_perr      out  head-entry parity flag
//   out_serr      out  head-entry stop flag
//   out_valid     out  head entry present
//   out_ready     in   consumer accepts head
//   count         out  number of entries held
//   full, empty   out  occupancy flags
//   overflow      out  sticky: a frame was lost because the FIFO was full
//   overflow_clr  in   clears overflow
//   err_drop_cnt  out  (macro only) number of discarded error frames
//
// Handshake: the head entry transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and
// out_ready while out_valid is low has no effect. The producer side has no
// back-pressure: data_valid is a push request that is either stored or, if
// the FIFO is full with no pop in the same cycle, dropped and flagged.
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      P_DATA,
    input  logic                   data_valid,
    input  logic                   parity_error,
    input  logic                   stop_error,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_perr,
    output logic                   out_serr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   overflow_clr
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    output logic [7:0]             err_drop_cnt
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int FRAME_W = DATA_W + FLAG_W;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [FRAME_W-1:0] wr_frame;
    logic [FRAME_W-1:0] rd_frame;

    logic push_req;   // frame eligible for storage
    logic pop;
    logic wr_en;
    logic ovf_event;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic err_frame;

    // Error frames are filtered before the full check, so they can never
    // cause an overflow.
    assign err_frame = data_valid & (parity_error | stop_error);
    assign push_req  = data_valid & ~(parity_error | stop_error);
`else
    assign push_req  = data_valid;
`endif

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    // A pop in the same cycle frees the slot being written, so a full FIFO
    // still accepts the push.
    assign wr_en     = push_req & (~full | pop);
    assign ovf_event = push_req & full & ~pop;

    assign wr_frame  = {P_DATA, parity_error, stop_error};

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_frame),
        .rd_addr (rd_ptr),
        .rd_data (rd_frame)
    );

    assign out_data = rd_frame[FRAME_W-1:FLAG_W];
    assign out_perr = rd_frame[1];
    assign out_serr = rd_frame[0];

    // Pointers are AW bits wide and wrap by overflow of the addition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    // A new overflow event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_drop_cnt <= '0;
        end else if (err_frame && (err_drop_cnt != 8'hFF)) begin
            err_drop_cnt <= err_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed self-checking bench for uart_rx_fifo at default geometry
// (DEPTH=8, DATA_W=8). Inputs change on the falling edge; outputs are
// sampled on the falling edge, half a cycle after the rising edge that
// updated them. Expected head frames are kept in exp_q as
// {data, perr, serr}.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int FW     = DATA_W + 2;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              parity_error;
    logic              stop_error;
    logic [DATA_W-1:0] out_data;
    logic              out_perr;
    logic              out_serr;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              overflow_clr;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0]        err_drop_cnt;
`endif

    logic [FW-1:0] exp_q [$];
    int            n_total;
    int            n_pass;
    int            n_fail;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .out_data     (out_data),
        .out_perr     (out_perr),
        .out_serr     (out_serr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_DROP_ERR_EN
        ,
        .err_drop_cnt (err_drop_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame for a single cycle, no pop.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic se);
        P_DATA       = d;
        parity_error = pe;
        stop_error   = se;
        data_valid   = 1'b1;
        @(negedge clk);
        data_valid   = 1'b0;
        parity_error = 1'b0;
        stop_error   = 1'b0;
    endtask

    // Check the head against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        logic [FW-1:0] exp_f;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp_f = exp_q.pop_front();
            check({tag, "_frame"}, {22'd0, out_data, out_perr, out_serr}, {22'd0, exp_f});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_pass       = 0;
        n_fail       = 0;
        P_DATA       = '0;
        data_valid   = 1'b0;
        parity_error = 1'b0;
        stop_error   = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;

        // Reset: a real falling edge on rst, checked before any clock edge.
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_count",    {28'd0, count},     32'd0);
        check("rst_empty",    {31'd0, empty},     32'd1);
        check("rst_full",     {31'd0, full},      32'd0);
        check("rst_valid",    {31'd0, out_valid}, 32'd0);
        check("rst_overflow", {31'd0, overflow},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single clean push, consumer not ready.
        push_frame(8'hA5, 1'b0, 1'b0);
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        check("a5_valid", {31'd0, out_valid}, 32'd1);
        check("a5_data",  {24'd0, out_data},  32'hA5);
        check("a5_count", {28'd0, count},     32'd1);
        check("a5_empty", {31'd0, empty},     32'd0);
        pop_check("a5_pop");
        check("a5_empty_after", {31'd0, empty}, 32'd1);

        // Fill with 0x00..0x07, then a ninth frame that must be dropped.
        for (int i = 0; i < DEPTH; i++) begin
            push_frame(8'(i), 1'b0, 1'b0);
            exp_q.push_back({8'(i), 2'b00});
        end
        check("fill_full",   {31'd0, full},     32'd1);
        check("fill_count",  {28'd0, count},    32'd8);
        check("fill_no_ovf", {31'd0, overflow}, 32'd0);
        push_frame(8'hFF, 1'b0, 1'b0);
        check("ovf_set",   {31'd0, overflow}, 32'd1);
        check("ovf_count", {28'd0, count},    32'd8);

        // Clear coincides with a new overflowing push: overflow stays set.
        P_DATA       = 8'hEE;
        data_valid   = 1'b1;
        overflow_clr = 1'b1;
        @(negedge clk);
        data_valid   = 1'b0;
        check("clr_vs_ovf", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        overflow_clr = 1'b0;
        check("clr_alone", {31'd0, overflow}, 32'd0);

        // Push and pop together while full: head 0x00 leaves, 0x3C enters.
        check("pp_head", {24'd0, out_data}, {24'd0, exp_q[0][FW-1:2]});
        void'(exp_q.pop_front());
        P_DATA     = 8'h3C;
        data_valid = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        out_ready  = 1'b0;
        exp_q.push_back({8'h3C, 2'b00});
        check("pp_count", {28'd0, count},    32'd8);
        check("pp_ovf",   {31'd0, overflow}, 32'd0);
        check("pp_full",  {31'd0, full},     32'd1);

        // Drain: 0x01..0x07 then 0x3C.
        for (int i = 0; i < DEPTH; i++) begin
            pop_check("drain");
        end
        check("drain_empty", {31'd0, empty},     32'd1);
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Error-flagged frames.
        push_frame(8'h55, 1'b1, 1'b0);
        push_frame(8'h99, 1'b0, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        check("perr_empty",  {31'd0, empty},        32'd1);
        check("perr_drops",  {24'd0, err_drop_cnt}, 32'd2);
        check("perr_no_ovf", {31'd0, overflow},     32'd0);
`else
        exp_q.push_back({8'h55, 2'b10});
        exp_q.push_back({8'h99, 2'b01});
        check("perr_count", {28'd0, count}, 32'd2);
        pop_check("perr_pop");
        pop_check("serr_pop");
`endif

        // Reset mid-operation with 5 entries stored.
        for (int i = 0; i < 5; i++) begin
            push_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        end
        check("pre_rst_count", {28'd0, count}, 32'd5);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_count", {28'd0, count},     32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ovf",   {31'd0, overflow},  32'd0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        check("mid_rst_drops", {24'd0, err_drop_cnt}, 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_frame(8'h81, 1'b0, 1'b0);
        exp_q.push_back({8'h81, 2'b00});
        check("post_rst_count", {28'd0, count}, 32'd1);
        pop_check("post_rst_pop");
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        // out_ready while empty must not disturb anything.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("empty_ready_count", {28'd0, count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of frame entries; power of two, >= 2.
REQ-002 Parameter DATA_W, default 8, data bits per frame.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 P_DATA  input  DATA_W  received byte from RX top.
REQ-006 data_valid  input  1  one-cycle pulse marking a completed frame on P_DATA.
REQ-007 parity_error, stop_error  input  1 each  error flags, qualified by data_valid.
REQ-008 out_data  output  DATA_W  head-entry data.
REQ-009 out_perr, out_serr  output  1 each  head-entry error flags.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-012 count  output  clog2(DEPTH)+1  entries held.
REQ-013 full, empty  output  1 each  occupancy flags.
REQ-014 overflow  output  1  sticky: frame lost because FIFO full.
REQ-015 overflow_clr  input  1  clears overflow.

Function
REQ-016 Push = data_valid; pop = out_valid & out_ready.
REQ-017 Accepted push writes {P_DATA, parity_error, stop_error} at write pointer, then advances it mod DEPTH.
REQ-018 Pop advances read pointer mod DEPTH; out_* show mem[rd_ptr] combinationally, out_valid = !empty.
REQ-019 Latency: push accepted at edge N into empty FIFO gives out_valid high after edge N; no bypass.
REQ-020 count: +1 push only, -1 pop only, unchanged on push+pop or neither; full = (count==DEPTH), empty = (count==0).
REQ-021 Push while full and no pop: frame dropped, storage/pointers unchanged, overflow set.
REQ-022 Push and pop in same cycle while full: push accepted, count stays DEPTH, no overflow.
REQ-023 Pop while empty impossible (out_valid low); out_ready ignored.
REQ-024 overflow_clr clears overflow next edge; a simultaneous new overflow event wins (overflow stays 1).
REQ-025 Pointers use clog2(DEPTH) bits and wrap naturally; no other wrap handling.

Reset
REQ-026 On rst low, immediately: pointers 0, count 0, empty 1, full 0, out_valid 0, overflow 0.
REQ-027 Memory contents are not reset; out_data/out_perr/out_serr are don't-care while out_valid is 0.
REQ-028 Reset mid-operation discards all stored frames; first push after release behaves as into empty FIFO.

Configuration
REQ-029 Macro UART_RX_FIFO_DROP_ERR_EN selects error-frame policy.
REQ-030 Defined: frames with parity_error or stop_error never written, never set overflow; extra output err_drop_cnt (8 bits, saturating at 255, reset 0) increments per discarded frame.
REQ-031 Undefined: all frames stored with flags; err_drop_cnt port absent.

Structure
REQ-032 Shared package uart_rx_pkg holds the frame typedef (data, perr, serr) and the default DEPTH/DATA_W constants.
REQ-033 Storage lives in one sub-module uart_rx_fifo_mem (register array, one write port, one async read port); pointer/count/flag logic stays in uart_rx_fifo.

Verification
REQ-034 Push 0xA5 clean, out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1, empty=0.
REQ-035 Push 8 frames 0x00..0x07 then 9th 0xFF, out_ready=0 -> full=1, overflow=1, then pop all yields 0x00..0x07 in order.
REQ-036 Full FIFO, push 0x3C with out_ready=1 same cycle -> count stays 8, overflow=0, 0x3C read last.
REQ-037 Push 0x55 with parity_error=1 -> macro undefined: out_perr=1 on pop; defined: not stored, err_drop_cnt=1, empty stays 1.
REQ-038 Hold overflow=1, assert overflow_clr with overflowing push same cycle -> overflow remains 1; clr alone next cycle -> 0.
REQ-039 Assert rst low with 5 entries stored -> count=0, out_valid=0, overflow=0 without clock edge; push 0x81 after release reads back 0x81.
